// File: rtl/zest_spi_arb.sv
// Round-robin arbiter and SPI/uWire master shared by the Zest board peripherals.
// Runs one latched transaction at a time; read-back comes from per-device miso after SDIO turnaround.
module zest_spi_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NCS  = 6,
  parameter int unsigned DW   = 24,
  parameter int unsigned DIV  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*3-1:0]  i_cmd_cs,
  input  logic [NREQ*5-1:0]  i_cmd_len,
  input  logic [NREQ*5-1:0]  i_cmd_turn,
  input  logic [NREQ*DW-1:0] i_cmd_data,
  output logic [NREQ-1:0]    o_gnt,
  output logic               o_done,
  output logic               o_err,
  output logic [DW-1:0]      o_rdata,
  output logic               o_busy,
  output logic               o_sclk,
  output logic               o_sdio_o,
  output logic               o_sdio_oe,
  input  logic [NCS-1:0]     i_miso,
  output logic [NCS-1:0]     o_cs_n
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(DIV);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StHold, StGap} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [4:0]      r_bit, w_bit_d, r_len, w_len_d, r_turn, w_turn_d;
  logic [2:0]      r_cs, w_cs_d;
  logic [DW-1:0]   r_data, w_data_d, r_sr, w_sr_d, r_rdata, w_rdata_d;
  logic [IW-1:0]   r_rr, w_rr_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic            r_done, w_done_d, r_err, w_err_d;
  logic            r_sclk, w_sclk_d, r_sdio_o, w_sdio_o_d, r_sdio_oe, w_sdio_oe_d;
  logic [NCS-1:0]  r_cs_n, w_cs_n_d;

  logic [2:0]      w_cs_arr   [NREQ];
  logic [4:0]      w_len_arr  [NREQ];
  logic [4:0]      w_turn_arr [NREQ];
  logic [DW-1:0]   w_data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_cs_arr[g]   = i_cmd_cs[3*g +: 3];
    assign w_len_arr[g]  = i_cmd_len[5*g +: 5];
    assign w_turn_arr[g] = i_cmd_turn[5*g +: 5];
    assign w_data_arr[g] = i_cmd_data[DW*g +: DW];
  end

  // Search starts just after the last winner, so a held request drops to lowest priority.
  logic          w_any;
  logic [IW-1:0] w_sel, w_cand;
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_rr;
    w_cand = r_rr;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_cand = IW'((32'(r_rr) + i) % NREQ);
      if (!w_any && i_req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  logic       w_reject, w_cnt_last, w_more, w_oe_nx;
  logic [5:0] w_bit_nx;
  assign w_reject   = (w_len_arr[w_sel] == 5'd0) || (32'(w_len_arr[w_sel]) > DW) ||
                      (32'(w_cs_arr[w_sel]) >= NCS);
  assign w_cnt_last = (r_cnt == CW'(DIV - 1));
  assign w_bit_nx   = {1'b0, r_bit} + 6'd1;
  assign w_more     = w_bit_nx < {1'b0, r_len};
  assign w_oe_nx    = w_bit_nx < {1'b0, r_turn};

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + CW'(1);
    w_bit_d     = r_bit;
    w_len_d     = r_len;
    w_turn_d    = r_turn;
    w_cs_d      = r_cs;
    w_data_d    = r_data;
    w_sr_d      = r_sr;
    w_rr_d      = r_rr;
    w_gnt_d     = r_gnt;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    w_rdata_d   = r_rdata;
    w_sdio_o_d  = r_sdio_o;
    w_sdio_oe_d = r_sdio_oe;
    case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_any) begin
          w_gnt_d  = NREQ'(1) << w_sel;
          w_rr_d   = w_sel;
          w_cs_d   = w_cs_arr[w_sel];
          w_len_d  = w_len_arr[w_sel];
          w_turn_d = w_turn_arr[w_sel];
          w_bit_d  = '0;
          w_sr_d   = '0;
          if (w_reject) begin
            w_done_d  = 1'b1;
            w_err_d   = 1'b1;
            w_state_d = StGap;
          end else begin
            w_data_d    = w_data_arr[w_sel] << 1;
            w_sdio_o_d  = w_data_arr[w_sel][DW-1];
            w_sdio_oe_d = (w_turn_arr[w_sel] != 5'd0);
            w_state_d   = StShiftLo;
          end
        end
      end
      StShiftLo: begin
        if (w_cnt_last) begin
          w_cnt_d   = '0;
          w_state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (r_cnt == '0) w_sr_d = {r_sr[DW-2:0], i_miso[r_cs]};
        if (w_cnt_last) begin
          w_cnt_d = '0;
          if (w_more) begin
            w_bit_d     = w_bit_nx[4:0];
            w_data_d    = r_data << 1;
            w_sdio_o_d  = r_data[DW-1];
            w_sdio_oe_d = w_oe_nx;
            w_state_d   = StShiftLo;
          end else begin
            w_state_d = StHold;
          end
        end
      end
      StHold: begin
        if (w_cnt_last) begin
          w_cnt_d     = '0;
          w_done_d    = 1'b1;
          w_err_d     = 1'b0;
          w_rdata_d   = r_sr;
          w_sdio_o_d  = 1'b0;
          w_sdio_oe_d = 1'b0;
          w_state_d   = StGap;
        end
      end
      StGap: begin
        w_gnt_d = '0;
        if (w_cnt_last) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Pin outputs are registered from the next state so they stay glitch-free.
    w_sclk_d = (w_state_d == StShiftHi);
    w_cs_n_d = '1;
    if (w_state_d inside {StShiftLo, StShiftHi, StHold}) w_cs_n_d = ~(NCS'(1) << w_cs_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_len     <= '0;
      r_turn    <= '0;
      r_cs      <= '0;
      r_data    <= '0;
      r_sr      <= '0;
      r_rr      <= IW'(NREQ - 1);
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_sclk    <= 1'b0;
      r_sdio_o  <= 1'b0;
      r_sdio_oe <= 1'b0;
      r_cs_n    <= '1;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_bit     <= w_bit_d;
      r_len     <= w_len_d;
      r_turn    <= w_turn_d;
      r_cs      <= w_cs_d;
      r_data    <= w_data_d;
      r_sr      <= w_sr_d;
      r_rr      <= w_rr_d;
      r_gnt     <= w_gnt_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      r_rdata   <= w_rdata_d;
      r_sclk    <= w_sclk_d;
      r_sdio_o  <= w_sdio_o_d;
      r_sdio_oe <= w_sdio_oe_d;
      r_cs_n    <= w_cs_n_d;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_rdata   = r_rdata;
  assign o_busy    = (r_state != StIdle);
  assign o_sclk    = r_sclk;
  assign o_sdio_o  = r_sdio_o;
  assign o_sdio_oe = r_sdio_oe;
  assign o_cs_n    = r_cs_n;

endmodule

// File: tb/tb_zest_spi_arb.sv
// Directed self-checking bench for zest_spi_arb: write, 3-wire read, arbitration, reject,
// reset mid-shift and late request drop.
module tb_zest_spi_arb;
  localparam int NREQ = 4;
  localparam int NCS  = 6;
  localparam int DW   = 24;
  localparam int DIV  = 4;
  localparam int WR_LOW  = 2 * DIV * 24 + DIV;  // cs_n low cycles for a 24-bit transfer
  localparam int WR_DONE = WR_LOW + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [11:0]     cmd_cs;
  logic [19:0]     cmd_len, cmd_turn;
  logic [95:0]     cmd_data;
  logic [3:0]      gnt;
  logic            done, err, busy, sclk, sdio_o, sdio_oe;
  logic [23:0]     rdata;
  logic [5:0]      miso = '1;
  logic [5:0]      cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  zest_spi_arb #(.NREQ(NREQ), .NCS(NCS), .DW(DW), .DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_cmd_cs  (cmd_cs),
    .i_cmd_len (cmd_len),
    .i_cmd_turn(cmd_turn),
    .i_cmd_data(cmd_data),
    .o_gnt     (gnt),
    .o_done    (done),
    .o_err     (err),
    .o_rdata   (rdata),
    .o_busy    (busy),
    .o_sclk    (sclk),
    .o_sdio_o  (sdio_o),
    .o_sdio_oe (sdio_oe),
    .i_miso    (miso),
    .o_cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  // Bus observer and miso model; samples 2 ns after each rising edge.
  int          mon_rises, mon_falls, mon_cs_total, mon_oe_fall_at, mon_done_cnt;
  int          mon_cs_low [NCS];
  logic [23:0] mon_mosi;
  logic [23:0] miso_pat = 24'h0;
  logic        mon_prev_sclk = 1'b0;

  always @(posedge clk) begin
    #2;
    if (sclk && !mon_prev_sclk) begin
      mon_rises++;
      mon_mosi = {mon_mosi[22:0], sdio_o};
    end
    if (!sclk && mon_prev_sclk) mon_falls++;
    if (cs_n == '1) mon_falls = 0;
    mon_prev_sclk = sclk;
    if (cs_n != '1) begin
      mon_cs_total++;
      if (!sdio_oe && mon_oe_fall_at < 0) mon_oe_fall_at = mon_cs_total;
    end
    for (int i = 0; i < NCS; i++) if (!cs_n[i]) mon_cs_low[i]++;
    if (done) mon_done_cnt++;
    miso = '1;
    miso[1] = (mon_falls < 24) ? miso_pat[23 - mon_falls] : 1'b0;
  end

  task automatic mon_clear();
    mon_rises = 0; mon_falls = 0; mon_cs_total = 0; mon_oe_fall_at = -1; mon_done_cnt = 0;
    mon_mosi = '0;
    for (int i = 0; i < NCS; i++) mon_cs_low[i] = 0;
  endtask

  task automatic set_cmd(input int r, input logic [2:0] cs, input logic [4:0] len,
                         input logic [4:0] turn, input logic [23:0] data);
    cmd_cs[r*3 +: 3]    = cs;
    cmd_len[r*5 +: 5]   = len;
    cmd_turn[r*5 +: 5]  = turn;
    cmd_data[r*24 +: 24] = data;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, want 0", busy, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; cmd_cs = '0; cmd_len = '0; cmd_turn = '0; cmd_data = '0;
    mon_clear();
    repeat (2) @(negedge clk);
    n_tests++; if (cs_n !== 6'h3F) begin n_fail++; $display("FAIL reset_cs_n: got %h want 3f", cs_n); end
    n_tests++; if ({sclk, sdio_o, sdio_oe} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pins: got %b want 000", {sclk, sdio_o, sdio_oe}); end
    n_tests++; if ({gnt, done, err, busy} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {gnt, done, err, busy}); end
    n_tests++; if (rdata !== 24'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int order [5];
    int n_g = 0, k = 0, prev_rise = -1, bad_iv = 0, bad_oh = 0, bad_ov = 0;
    int gap_run = 0, min_gap = 1000;
    bit seen_pulse = 0;
    logic [3:0] prev_gnt = '0;
    for (int r = 0; r < 4; r++) set_cmd(r, 3'(r), 5'd2, 5'd2, 24'hC00000);
    mon_clear();
    req = 4'hF;
    while (n_g < 5 && k < 400) begin
      @(negedge clk); k++;
      if (gnt != '0 && !$onehot(gnt)) bad_oh++;
      if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) bad_ov++;
      if (cs_n == '1) gap_run++;
      else begin
        if (seen_pulse && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
        gap_run = 0; seen_pulse = 1;
      end
      if (gnt != '0 && prev_gnt == '0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) order[n_g] = i;
        if (prev_rise >= 0 && (k - prev_rise) != 2*DIV*2 + 2*DIV + 1) bad_iv++;
        prev_rise = k;
        n_g++;
      end
      prev_gnt = gnt;
    end
    req = '0;
    n_tests++; if (n_g != 5) begin n_fail++; $display("FAIL arb_grants: got %0d want 5", n_g); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (i < n_g && order[i] != i % 4) begin
        n_fail++; $display("FAIL arb_order[%0d]: got %0d want %0d", i, order[i], i % 4); end
    end
    n_tests++; if (bad_oh != 0) begin n_fail++; $display("FAIL arb_onehot: got %0d bad want 0", bad_oh); end
    n_tests++; if (bad_ov != 0) begin n_fail++; $display("FAIL arb_overlap: got %0d want 0", bad_ov); end
    n_tests++; if (bad_iv != 0) begin n_fail++; $display("FAIL arb_interval: got %0d bad want 0", bad_iv); end
    n_tests++; if (min_gap != DIV + 1) begin
      n_fail++; $display("FAIL arb_gap: got %0d want %0d", min_gap, DIV + 1); end
    wait_idle();
  endtask

  task automatic test_single_write();
    int k = 0, got = -1;
    set_cmd(1, 3'd3, 5'd24, 5'd24, 24'h123456);
    mon_clear();
    req = 4'b0010;
    while (k < 400 && got < 0) begin
      @(negedge clk); k++;
      if (k == 1) begin
        n_tests++; if (gnt !== 4'b0010 || cs_n !== 6'b110111) begin
          n_fail++; $display("FAIL wr_grant: got gnt=%b cs_n=%b want 0010 110111", gnt, cs_n); end
      end
      if (done) begin got = k; req = '0; end
    end
    n_tests++; if (got != WR_DONE) begin n_fail++; $display("FAIL wr_done_cycle: got %0d want %0d", got, WR_DONE); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
    n_tests++; if (rdata !== 24'hFFFFFF) begin n_fail++; $display("FAIL wr_rdata: got %h want ffffff", rdata); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_at_done: got %b want 1", busy); end
    @(negedge clk);
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wr_gnt_clear: got %b want 0000", gnt); end
    n_tests++; if (mon_cs_low[3] != WR_LOW) begin
      n_fail++; $display("FAIL wr_cs_low: got %0d want %0d", mon_cs_low[3], WR_LOW); end
    n_tests++; if (mon_rises != 24) begin n_fail++; $display("FAIL wr_sclk_pulses: got %0d want 24", mon_rises); end
    n_tests++; if (mon_mosi !== 24'h123456) begin n_fail++; $display("FAIL wr_mosi: got %h want 123456", mon_mosi); end
    n_tests++; if (mon_oe_fall_at != -1) begin n_fail++; $display("FAIL wr_oe: got %0d want -1", mon_oe_fall_at); end
    wait_idle();
  endtask

  task automatic test_read_3wire();
    int k = 0, got = -1;
    set_cmd(2, 3'd1, 5'd24, 5'd16, 24'h3C5A00);
    miso_pat = 24'h0000A5;
    mon_clear();
    req = 4'b0100;
    while (k < 400 && got < 0) begin
      @(negedge clk); k++;
      if (done) begin got = k; req = '0; end
    end
    n_tests++; if (got != WR_DONE) begin n_fail++; $display("FAIL rd_done_cycle: got %0d want %0d", got, WR_DONE); end
    n_tests++; if (rdata !== 24'h0000A5) begin n_fail++; $display("FAIL rd_rdata: got %h want 0000a5", rdata); end
    n_tests++; if (mon_oe_fall_at != 1 + 2*DIV*16) begin
      n_fail++; $display("FAIL rd_oe_fall: got %0d want %0d", mon_oe_fall_at, 1 + 2*DIV*16); end
    n_tests++; if (mon_mosi[23:8] !== 16'h3C5A) begin n_fail++; $display("FAIL rd_mosi: got %h want 3c5a", mon_mosi[23:8]); end
    wait_idle();
  endtask

  task automatic test_reject();
    int k = 0, d1 = -1, d2 = -1;
    logic e2 = 1'b0;
    set_cmd(3, 3'd0, 5'd0, 5'd0, 24'hFFFFFF);
    mon_clear();
    req = 4'b1000;
    @(negedge clk);
    n_tests++; if ({done, err, gnt} !== 6'b111000) begin
      n_fail++; $display("FAIL rej_len0: got done/err/gnt=%b want 111000", {done, err, gnt}); end
    n_tests++; if (rdata !== 24'h0000A5) begin n_fail++; $display("FAIL rej_rdata: got %h want 0000a5", rdata); end
    req = '0;
    @(negedge clk);
    n_tests++; if ({done, gnt} !== 5'b00000) begin
      n_fail++; $display("FAIL rej_clear: got done/gnt=%b want 00000", {done, gnt}); end
    wait_idle();
    set_cmd(0, 3'd7, 5'd8, 5'd8, 24'hFFFFFF);
    req = 4'b0001;
    while (k < 40 && d2 < 0) begin
      @(negedge clk); k++;
      if (done) begin
        if (d1 < 0) d1 = k;
        else begin d2 = k; e2 = err; req = '0; end
      end
    end
    req = '0;
    n_tests++; if (d1 != 1) begin n_fail++; $display("FAIL rej_cs_first: got %0d want 1", d1); end
    n_tests++; if (d2 != DIV + 2) begin n_fail++; $display("FAIL rej_regrant: got %0d want %0d", d2, DIV + 2); end
    n_tests++; if (e2 !== 1'b1) begin n_fail++; $display("FAIL rej_cs_err: got %b want 1", e2); end
    wait_idle();
    n_tests++; if (mon_rises != 0 || mon_cs_total != 0) begin
      n_fail++; $display("FAIL rej_bus_quiet: got rises=%0d cs=%0d want 0 0", mon_rises, mon_cs_total); end
    n_tests++; if ({err, rdata} !== {1'b1, 24'h0000A5}) begin
      n_fail++; $display("FAIL rej_hold: got err=%b rdata=%h want 1 0000a5", err, rdata); end
  endtask

  task automatic test_late_drop();
    int k = 0, got = -1;
    set_cmd(1, 3'd2, 5'd24, 5'd24, 24'hF0F0F0);
    mon_clear();
    req = 4'b0010;
    while (k < 400 && got < 0) begin
      @(negedge clk); k++;
      if (mon_rises == 5) req = '0;
      if (done) got = k;
    end
    req = '0;
    n_tests++; if (got != WR_DONE) begin n_fail++; $display("FAIL drop_done: got %0d want %0d", got, WR_DONE); end
    n_tests++; if (mon_rises != 24) begin n_fail++; $display("FAIL drop_pulses: got %0d want 24", mon_rises); end
    n_tests++; if (mon_mosi !== 24'hF0F0F0) begin n_fail++; $display("FAIL drop_mosi: got %h want f0f0f0", mon_mosi); end
    n_tests++; if (mon_cs_low[2] != WR_LOW) begin
      n_fail++; $display("FAIL drop_cs_low: got %0d want %0d", mon_cs_low[2], WR_LOW); end
    wait_idle();
  endtask

  task automatic test_reset_mid_shift();
    int k = 0, got = -1;
    set_cmd(2, 3'd0, 5'd24, 5'd24, 24'hAAAAAA);
    mon_clear();
    req = 4'b0100;
    while (k < 400 && mon_rises < 10) begin @(negedge clk); k++; end
    n_tests++; if (cs_n !== 6'b111110) begin n_fail++; $display("FAIL rst_pre_cs: got %b want 111110", cs_n); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (cs_n !== 6'h3F || sclk !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got cs_n=%b sclk=%b want 111111 0", cs_n, sclk); end
    mon_done_cnt = 0;
    repeat (5) @(negedge clk);
    n_tests++; if (mon_done_cnt != 0 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL rst_no_done: got done=%0d gnt=%b want 0 0000", mon_done_cnt, gnt); end
    for (int r = 0; r < 4; r++) set_cmd(r, 3'(r), 5'd2, 5'd2, 24'h400000);
    rst_n = 1'b1;
    req = 4'hF;
    k = 0;
    while (k < 100 && got < 0) begin
      @(negedge clk); k++;
      if (k == 1) begin
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_prio: got %b want 0001", gnt); end
      end
      if (done) begin got = k; req = '0; end
    end
    req = '0;
    n_tests++; if (got != 2*DIV*2 + DIV + 1) begin
      n_fail++; $display("FAIL rst_after_done: got %0d want %0d", got, 2*DIV*2 + DIV + 1); end
    wait_idle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arbitration();
    test_single_write();
    test_read_3wire();
    test_reject();
    test_late_drop();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
